// File: rtl/ride_dispatcher.sv
// Ride dispatcher: three rider queues served round-robin by a single car that
// cycles BOARD -> RUN -> UNLOAD, with each phase timed in tick pulses.
module ride_dispatcher #(
    parameter int BOARD_TICKS  = 2,
    parameter int RUN_TICKS    = 8,
    parameter int UNLOAD_TICKS = 2,
    parameter int QMAX         = 5
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       tick,
    input  logic [2:0] arr,
    input  logic       hold,
    output logic [2:0] q0_cnt,
    output logic [2:0] q1_cnt,
    output logic [2:0] q2_cnt,
    output logic [1:0] state,
    output logic [2:0] grant,
    output logic [1:0] load,
    output logic [2:0] arr_drop,
    output logic [7:0] rides_done
);
    localparam int TMAX_BR = (BOARD_TICKS > RUN_TICKS) ? BOARD_TICKS : RUN_TICKS;
    localparam int TMAX    = (TMAX_BR > UNLOAD_TICKS) ? TMAX_BR : UNLOAD_TICKS;
    localparam int TW      = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BOARD  = 2'b01,
        S_RUN    = 2'b10,
        S_UNLOAD = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic [2:0]      r_q [3];
    logic [2:0]      w_q_next [3];
    logic [2:0]      r_grant;
    logic [2:0]      w_grant_next;
    logic [1:0]      r_load;
    logic [1:0]      w_load_next;
    logic [2:0]      r_drop;
    logic [2:0]      w_drop_next;
    logic [7:0]      r_rides;
    logic [7:0]      w_rides_next;
    logic [1:0]      r_last;
    logic [1:0]      w_last_next;

    logic [2:0]      w_q_nz;
    logic [1:0]      w_order [3];
    logic [1:0]      w_pick;
    logic            w_pick_valid;
    logic [2:0]      w_pick_q;
    logic [1:0]      w_take_load;
    logic            w_dispatch;

    // Search order starts at the line after the last one granted.
    always_comb begin
        w_order[0] = 2'd0;
        w_order[1] = 2'd1;
        w_order[2] = 2'd2;
        case (r_last)
            2'd0: begin
                w_order[0] = 2'd1;
                w_order[1] = 2'd2;
                w_order[2] = 2'd0;
            end
            2'd1: begin
                w_order[0] = 2'd2;
                w_order[1] = 2'd0;
                w_order[2] = 2'd1;
            end
            default: ;
        endcase
        w_pick       = w_order[0];
        w_pick_valid = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (w_q_nz[w_order[k]]) begin
                w_pick       = w_order[k];
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_pick_q    = r_q[w_pick];
    assign w_take_load = (w_pick_q >= 3'd2) ? 2'd2 : w_pick_q[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_line
            logic [2:0] w_take;
            logic [2:0] w_after;
            logic       w_accept;

            assign w_q_nz[gi]      = (r_q[gi] != 3'd0);
            assign w_take          = (w_dispatch && (w_pick == 2'(gi))) ? {1'b0, w_take_load} : 3'd0;
            assign w_after         = r_q[gi] - w_take;
            assign w_accept        = arr[gi] && (w_after < 3'(QMAX));
            assign w_q_next[gi]    = w_after + {2'b00, w_accept};
            assign w_drop_next[gi] = arr[gi] && !w_accept;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_grant_next = r_grant;
        w_load_next  = r_load;
        w_rides_next = r_rides;
        w_last_next  = r_last;
        w_dispatch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!hold && w_pick_valid) begin
                    w_dispatch   = 1'b1;
                    w_state_next = S_BOARD;
                    w_grant_next = 3'b001 << w_pick;
                    w_load_next  = w_take_load;
                    w_timer_next = TW'(BOARD_TICKS);
                    w_last_next  = w_pick;
                end
            end
            S_BOARD: begin
                if (tick) begin
                    if (r_timer <= TW'(1)) begin
                        w_state_next = S_RUN;
                        w_timer_next = TW'(RUN_TICKS);
                    end else begin
                        w_timer_next = r_timer - TW'(1);
                    end
                end
            end
            S_RUN: begin
                if (tick) begin
                    if (r_timer <= TW'(1)) begin
                        w_state_next = S_UNLOAD;
                        w_timer_next = TW'(UNLOAD_TICKS);
                    end else begin
                        w_timer_next = r_timer - TW'(1);
                    end
                end
            end
            S_UNLOAD: begin
                if (tick) begin
                    if (r_timer <= TW'(1)) begin
                        w_state_next = S_IDLE;
                        w_timer_next = '0;
                        w_grant_next = 3'b000;
                        w_load_next  = 2'd0;
                        w_rides_next = r_rides + 8'd1;
                    end else begin
                        w_timer_next = r_timer - TW'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
                w_grant_next = 3'b000;
                w_load_next  = 2'd0;
            end
        endcase
    end

    // r_last resets to line 2 so that line 0 is searched first.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_grant <= 3'b000;
            r_load  <= 2'd0;
            r_drop  <= 3'b000;
            r_rides <= 8'd0;
            r_last  <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                r_q[i] <= 3'd0;
            end
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_grant <= w_grant_next;
            r_load  <= w_load_next;
            r_drop  <= w_drop_next;
            r_rides <= w_rides_next;
            r_last  <= w_last_next;
            for (int i = 0; i < 3; i++) begin
                r_q[i] <= w_q_next[i];
            end
        end
    end

    assign q0_cnt     = r_q[0];
    assign q1_cnt     = r_q[1];
    assign q2_cnt     = r_q[2];
    assign state      = r_state;
    assign grant      = r_grant;
    assign load       = r_load;
    assign arr_drop   = r_drop;
    assign rides_done = r_rides;

endmodule

// File: tb/tb_ride_dispatcher.sv
// Self-checking bench for ride_dispatcher: directed vector table, hand-written
// corner sequences and randomized traffic against a ride-level reference model.
module tb_ride_dispatcher;
    logic       clk = 1'b0;
    logic       RESET;
    logic       tick;
    logic [2:0] arr;
    logic       hold;
    logic [2:0] q0_cnt;
    logic [2:0] q1_cnt;
    logic [2:0] q2_cnt;
    logic [1:0] state;
    logic [2:0] grant;
    logic [1:0] load;
    logic [2:0] arr_drop;
    logic [7:0] rides_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ride_dispatcher dut (
        .CLOCK_50   (clk),
        .RESET      (RESET),
        .tick       (tick),
        .arr        (arr),
        .hold       (hold),
        .q0_cnt     (q0_cnt),
        .q1_cnt     (q1_cnt),
        .q2_cnt     (q2_cnt),
        .state      (state),
        .grant      (grant),
        .load       (load),
        .arr_drop   (arr_drop),
        .rides_done (rides_done)
    );

    localparam int B_T   = 2;
    localparam int R_T   = 8;
    localparam int U_T   = 2;
    localparam int TOTAL = B_T + R_T + U_T;
    localparam int QMAX  = 5;

    // Reference model: a ride is "elapsed ticks since dispatch"; phase derives from it.
    int         mq [3];
    bit         m_busy;
    int         m_el;
    int         m_line;
    int         m_load;
    int         m_last;
    int         m_rides;
    int         m_total;
    logic [2:0] m_drop;

    typedef struct {
        logic [2:0]  a;
        logic        h;
        logic        t;
        logic [26:0] exp;
    } vec_t;
    vec_t vecs [9];

    logic [2:0] dg [4];
    logic [1:0] dl [4];
    logic [2:0] eg [4];
    logic [1:0] el [4];
    int         n_disp;
    logic [1:0] prev_state;

    function automatic logic [26:0] mk(int q0, int q1, int q2, int st, int g, int ld, int dr, int rd);
        logic [26:0] v;
        v = {3'(q0), 3'(q1), 3'(q2), 2'(st), 3'(g), 2'(ld), 3'(dr), 8'(rd)};
        return v;
    endfunction

    function automatic logic [26:0] obs();
        return {q0_cnt, q1_cnt, q2_cnt, state, grant, load, arr_drop, rides_done};
    endfunction

    function automatic logic [26:0] model_obs();
        int st;
        int g;
        int ld;
        if (!m_busy) st = 0;
        else if (m_el < B_T) st = 1;
        else if (m_el < B_T + R_T) st = 2;
        else st = 3;
        g  = m_busy ? (1 << m_line) : 0;
        ld = m_busy ? m_load : 0;
        return mk(mq[0], mq[1], mq[2], st, g, ld, int'(m_drop), m_rides);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i] = 0;
        m_busy  = 1'b0;
        m_el    = 0;
        m_line  = 0;
        m_load  = 0;
        m_last  = 2;
        m_rides = 0;
        m_total = 0;
        m_drop  = 3'b000;
    endtask

    task automatic model_step(input logic [2:0] a, input logic h, input logic t);
        int  take [3];
        int  l;
        bit  found;
        for (int i = 0; i < 3; i++) take[i] = 0;
        found = 1'b0;
        if (!m_busy) begin
            if (!h) begin
                for (int k = 1; k <= 3; k++) begin
                    l = (m_last + k) % 3;
                    if (!found && mq[l] > 0) begin
                        found   = 1'b1;
                        take[l] = (mq[l] < 2) ? mq[l] : 2;
                        m_busy  = 1'b1;
                        m_el    = 0;
                        m_line  = l;
                        m_load  = take[l];
                        m_last  = l;
                    end
                end
            end
        end else if (t) begin
            m_el++;
            if (m_el == TOTAL) begin
                m_busy  = 1'b0;
                m_rides = (m_rides + 1) % 256;
                m_total++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            mq[i]     = mq[i] - take[i];
            m_drop[i] = 1'b0;
            if (a[i]) begin
                if (mq[i] < QMAX) mq[i]++;
                else m_drop[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [2:0] a, input logic h, input logic t);
        arr  = a;
        hold = h;
        tick = t;
        model_step(a, h, t);
        @(posedge clk);
        #1;
        chk("model", 32'(obs()), 32'(model_obs()));
        arr  = 3'b000;
        tick = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        arr   = 3'b000;
        tick  = 1'b0;
        #2;
        chk("async_reset", 32'(obs()), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        tick  = 1'b0;
        arr   = 3'b000;
        hold  = 1'b0;

        vecs[0] = '{3'b001, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{3'b000, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 1, 0, 0)};
        vecs[2] = '{3'b010, 1'b0, 1'b1, mk(0, 1, 0, 1, 1, 1, 0, 0)};
        vecs[3] = '{3'b010, 1'b0, 1'b1, mk(0, 2, 0, 2, 1, 1, 0, 0)};
        vecs[4] = '{3'b111, 1'b1, 1'b0, mk(1, 3, 1, 2, 1, 1, 0, 0)};
        vecs[5] = '{3'b010, 1'b1, 1'b0, mk(1, 4, 1, 2, 1, 1, 0, 0)};
        vecs[6] = '{3'b010, 1'b1, 1'b0, mk(1, 5, 1, 2, 1, 1, 0, 0)};
        vecs[7] = '{3'b010, 1'b1, 1'b0, mk(1, 5, 1, 2, 1, 1, 2, 0)};
        vecs[8] = '{3'b000, 1'b1, 1'b0, mk(1, 5, 1, 2, 1, 1, 0, 0)};

        eg[0] = 3'b001; el[0] = 2'd2;
        eg[1] = 3'b010; el[1] = 2'd2;
        eg[2] = 3'b100; el[2] = 2'd1;
        eg[3] = 3'b001; el[3] = 2'd1;

        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].a, vecs[i].h, vecs[i].t);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end

        // Ride in progress with hold high must still complete.
        for (int i = 0; i < 8; i++) step(3'b000, 1'b1, 1'b1);
        chk("run_to_unload", 32'(state), 32'd3);
        step(3'b000, 1'b1, 1'b1);
        step(3'b000, 1'b1, 1'b1);
        chk("ride1_state", 32'(state), 32'd0);
        chk("ride1_count", 32'(rides_done), 32'd1);
        step(3'b000, 1'b1, 1'b0);
        chk("hold_idle", 32'({state, q1_cnt}), 32'({2'd0, 3'd5}));
        step(3'b010, 1'b0, 1'b0);
        chk("dispatch_edge_arr", 32'({state, grant, load, q1_cnt}), 32'({2'd1, 3'b010, 2'd2, 3'd4}));

        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        chk("run_load2", 32'({state, load}), 32'({2'd2, 2'd2}));
        do_reset();
        chk("rides_after_reset", 32'({state, rides_done}), 32'd0);

        step(3'b111, 1'b1, 1'b0);
        step(3'b011, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        chk("preload", 32'({q0_cnt, q1_cnt, q2_cnt, state}), 32'({3'd3, 3'd2, 3'd1, 2'd0}));
        n_disp     = 0;
        prev_state = state;
        for (int c = 0; c < 200 && !(n_disp >= 4 && state == 2'd0); c++) begin
            step(3'b000, 1'b0, 1'b1);
            if (state == 2'd1 && prev_state == 2'd0) begin
                if (n_disp < 4) begin
                    dg[n_disp] = grant;
                    dl[n_disp] = load;
                end
                n_disp++;
            end
            prev_state = state;
        end
        chk("rr_dispatch_count", 32'(n_disp), 32'd4);
        for (int i = 0; i < 4 && i < n_disp; i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(dg[i]), 32'(eg[i]));
            chk($sformatf("rr_load%0d", i), 32'(dl[i]), 32'(el[i]));
        end
        chk("rr_empty", 32'({q0_cnt, q1_cnt, q2_cnt, state}), 32'd0);

        do_reset();
        for (int c = 0; c < 6000 && m_total < 256; c++) step(3'b001, 1'b0, 1'b1);
        chk("wrap_reached", 32'(m_total), 32'd256);
        chk("wrap_rides", 32'(rides_done), 32'd0);

        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [2:0] a;
            logic       h;
            logic       t;
            for (int i = 0; i < 3; i++) a[i] = ($urandom_range(0, 9) < 3);
            h = ($urandom_range(0, 15) == 0) ? ~hold : hold;
            t = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(a, h, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ride_dispatcher.md
RIDE_DISPATCHER -- requirements
Module: ride_dispatcher

Interface
REQ-001 Parameter BOARD_TICKS, default 2, SHALL set the number of tick pulses spent in BOARD.
REQ-002 Parameter RUN_TICKS, default 8, SHALL set the number of tick pulses spent in RUN.
REQ-003 Parameter UNLOAD_TICKS, default 2, SHALL set the number of tick pulses spent in UNLOAD.
REQ-004 Parameter QMAX, default 5, SHALL set the maximum queue depth per line in groups (1 group = 4 riders).
REQ-005 CLOCK_50  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 RESET  in  1  reset; asynchronous, active-high.
REQ-007 tick  in  1  one-cycle time-base enable pulse.
REQ-008 arr  in  3  per-line arrival pulse; each high bit SHALL add one group to that line.
REQ-009 hold  in  1  maintenance hold; when high, no new ride SHALL start.
REQ-010 q0_cnt, q1_cnt, q2_cnt  out  3 each  registered queue depth per line, in groups.
REQ-011 state  out  2  IDLE=00, BOARD=01, RUN=10, UNLOAD=11.
REQ-012 grant  out  3  one-hot line being served; all zero in IDLE.
REQ-013 load  out  2  groups aboard the car, 0..2.
REQ-014 arr_drop  out  3  one-cycle pulse per line when an arrival is rejected.
REQ-015 rides_done  out  8  completed-ride counter.

Function
REQ-016 In IDLE with hold=0 and any queue >0, the block SHALL pick a line round-robin. The search SHALL start at the line after the last granted line, with order 0->1->2->0.
REQ-017 On that same edge, the block SHALL:
- enter BOARD;
- set grant one-hot to the chosen line;
- set load = min(q,2);
- decrement the chosen queue by load;
- load the phase timer with BOARD_TICKS.
REQ-018 The car SHALL board from the granted line only. Other lines SHALL NOT fill spare seats.
REQ-019 In BOARD, RUN and UNLOAD, the phase timer SHALL decrement only on cycles with tick=1.
REQ-020 A tick that finds the timer equal to 1 SHALL advance the state on that edge:
- BOARD->RUN, timer reloaded with RUN_TICKS;
- RUN->UNLOAD, timer reloaded with UNLOAD_TICKS;
- UNLOAD->IDLE.
REQ-021 On UNLOAD->IDLE, the block SHALL clear grant and load and increment rides_done. rides_done SHALL wrap 255->0.
REQ-022 hold SHALL be sampled only in IDLE. A ride in progress SHALL complete normally.
REQ-023 A line's next queue value SHALL be q - take + a, where take is the boarding decrement this cycle (0 if none) and a is 1 if an arrival is accepted, else 0.
REQ-024 An arrival SHALL be accepted iff q - take < QMAX. Otherwise the queue SHALL be unchanged by the arrival and the line's arr_drop bit SHALL pulse high for exactly that cycle.
REQ-025 Arrivals on all three lines in one cycle SHALL each be processed independently.
REQ-026 IDLE with all queues 0 SHALL remain IDLE. An arrival in that cycle SHALL be dispatched no earlier than the following edge, because dispatch uses registered counts.
REQ-027 The round-robin pointer SHALL update only when a grant is issued.
REQ-028 tick during IDLE SHALL have no effect.
REQ-029 Unused state encodings SHALL recover to IDLE on the next edge.
REQ-030 Minimum ride duration SHALL be BOARD_TICKS + RUN_TICKS + UNLOAD_TICKS tick pulses after dispatch.

Reset
REQ-031 While RESET=1, the block SHALL force immediately, independent of CLOCK_50:
- state=IDLE;
- all queues=0;
- grant=000, load=0, arr_drop=000, rides_done=0;
- timer=0;
- round-robin pointer so that line 0 has highest priority.
REQ-032 RESET asserted mid-ride SHALL abandon the ride with no increment of rides_done. After release, the block SHALL resume only from new arrivals.

Verification
REQ-033 Reset, then arr=001 once, hold=0 -> q0_cnt=1, then next edge state=BOARD, grant=001, load=1, q0_cnt=0; after 12 ticks state=IDLE and rides_done=1.
REQ-034 Preload q0=3, q1=2, q2=1 with hold=1, then release hold -> successive grants 001, 010, 100, 001 with loads 2, 2, 1, 1, and all queues 0 at the end.
REQ-035 Queue line 1 to 5, then pulse arr=010 -> arr_drop=010 for one cycle and q1_cnt stays 5. Repeat on the dispatch edge -> arrival accepted, q1_cnt=4.
REQ-036 Set hold=1 during RUN -> ride completes and state returns to IDLE. With queue nonempty and hold=1, state stays IDLE; release hold -> BOARD on the next edge.
REQ-037 Pulse RESET in RUN with load=2 -> all outputs zero and state=IDLE asynchronously; rides_done=0.
REQ-038 Run 256 rides -> rides_done wraps to 0.
